trail_stack: RTL and testbench
==============================

# trail_stack

Parametrised assignment trail for the DPLL solver: a LIFO of {var, val, type} entries pushed by `control` on every decision and implication. It has a hardware backtrack engine that unwinds implied entries, one per cycle, down to the most recent decision. On each unwind step it emits an unassign strobe for the var-state table. It then flips the decision in place, or reports that no decision remains (UNSAT). It replaces the fixed-size trace stack and removes the backtrack pop loop from `control`.

## Interface
- `VAR_BITS`, default 8: variable index width (matches `MAX_VARS_BITS`).
- `DEPTH`, default 256: maximum entries. Must be a power of two, ≥ 2.
- `CNT_BITS`, derived: $clog2(DEPTH)+1, the width of the count fields.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `push` in 1: push {`var_in`, `val_in`, `type_in`}.
- `var_in` in VAR_BITS: variable index to push.
- `val_in` in 1: assigned value to push.
- `type_in` in 1: entry type to push; 1 = decision, 0 = implied.
- `pop` in 1: discard the top entry.
- `backtrack` in 1: start a backtrack (single-cycle request).
- `var_out` out VAR_BITS, `val_out` out 1, `type_out` out 1: top entry. All zero when `empty`.
- `empty` out 1, `full` out 1: stack status.
- `count` out CNT_BITS: number of entries.
- `level` out CNT_BITS: number of type=1 entries currently on the stack.
- `bt_busy` out 1: backtrack in progress.
- `unassign_valid` out 1: one-cycle strobe; `unassign_var` is to be unassigned.
- `unassign_var` out VAR_BITS: variable to unassign.
- `bt_done` out 1: one-cycle pulse marking the end of a backtrack.
- `bt_none` out 1: qualifies `bt_done`; no decision was found, so the problem is UNSAT.
- `flip_var` out VAR_BITS, `flip_val` out 1: qualify `bt_done` when `bt_none`=0. They give the new assignment for the var-state table.
- `overflow` out 1: sticky; set by a push while full.

## Operation
- Storage is a register array plus stack pointer `sp` (= `count`). Top-of-stack outputs are combinational from entry `sp-1`.
- The FSM has three states: IDLE, UNWIND, DONE.

IDLE command handling (priority backtrack > push/pop):
- `backtrack`=1: go to UNWIND. Any push/pop in the same cycle is dropped.
- `push` only:
  - Not full: write the entry at `sp`, then `sp`++. `level`++ if `type_in`=1.
  - Full: no write; `overflow` is set.
- `pop` only:
  - Not empty: `sp`--. `level`-- if the top entry has type=1.
  - Empty: ignored.
- `push` and `pop` together:
  - Not empty: replace the top entry in place. `count` is unchanged; `level` is adjusted by old and new types.
  - Empty: treated as push only.

UNWIND, evaluated once per cycle on the top entry:
- Stack empty: `bt_done`=1 and `bt_none`=1 this cycle, then go to IDLE.
- Top type=0: pop it. `unassign_valid`=1 with `unassign_var` = its var. Stay in UNWIND.
- Top type=1: overwrite it in place with {var, ~val, type=0} and decrement `level`. `bt_done`=1, `bt_none`=0, `flip_var`=var, `flip_val`=~val. `unassign_valid`=0. Go to DONE.
- The flipped entry is stored as type 0, so a later backtrack unwinds past it.

DONE and inputs during backtrack:
- DONE lasts one cycle (`bt_busy`=0) and returns to IDLE. Its purpose is to let `control` restart BCP before issuing new commands; commands in DONE are accepted as in IDLE.
- While `bt_busy`=1, `push`, `pop` and `backtrack` are ignored.

## Timing
- Reset (`reset`=0, asynchronous): `sp`=0, `level`=0, FSM in IDLE, `overflow`=0. Therefore `empty`=1; `full`, `bt_busy`, `bt_done`, `bt_none` and `unassign_valid`=0; `var_out`, `val_out`, `type_out`, `unassign_var`, `flip_var`, `flip_val`=0.
  - Array contents need no reset.
  - Reset mid-backtrack aborts immediately with no `bt_done`.
- Push/pop: `count`, `level`, top outputs, `empty` and `full` update at the edge that samples the command (visible the next cycle).
- `bt_busy` is high from the cycle after `backtrack` is sampled through the `bt_done` cycle inclusive.
- Backtrack latency with k implied entries above the nearest decision:
  - `unassign_valid` is high in cycles 1..k after the request.
  - `bt_done` is in cycle k+1.
- With no decision on a stack of n entries: n unassign strobes, then `bt_done`+`bt_none` in cycle n+1. With n=0, `bt_done`+`bt_none` is in cycle 1.
- `unassign_*`, `bt_done`, `bt_none` and `flip_*` are combinational from the FSM state and the top entry.
  - `unassign_var`, `flip_var` and `flip_val` read 0 when not strobed.
  - `bt_none`=0 whenever `bt_done`=0.
- Pointer arithmetic is modulo-free: `sp` ranges 0..DEPTH and `full` = (`sp`==DEPTH).

## Test plan
- Reset then push {3,1,D}, {5,0,I}, {7,1,I}: `count`=3, `level`=1, top={7,1,0}. Pop: top={5,0,0}, `count`=2.
- Stack {3,1,D}, {5,0,I}, {7,1,I}, pulse `backtrack`:
  - Cycle 1: unassign 7. Cycle 2: unassign 5.
  - Cycle 3: `bt_done`, `flip_var`=3, `flip_val`=0.
  - Afterwards: top={3,0,0}, `count`=1, `level`=0.
- After the previous case, pulse `backtrack` again: cycle 1 unassign 3; cycle 2 `bt_done`+`bt_none`, `empty`=1.
- DEPTH=4: push 5 entries → `count`=4, `full`=1, `overflow`=1, top equals the 4th entry. Pop on empty is ignored with `count`=0.
- Push and pop together on top {5,0,I} with {9,1,D}: `count` unchanged, `level`+1, top={9,1,1}. `push`+`backtrack` together: push dropped, unwind starts.
- Assert `reset` low during the 2nd unwind cycle: all outputs reach reset values immediately and no `bt_done` occurs.

Source files
------------

// File: rtl/trail_stack.sv
// Assignment trail for the DPLL solver: LIFO of {var, val, type} entries with a
// hardware backtrack engine that unwinds implied entries and flips the last decision.
//
// state  | meaning
// IDLE   | accepting push/pop/backtrack
// UNWIND | popping implied entries one per cycle until a decision or empty
// DONE   | one cycle after a flip; commands accepted as in IDLE
module trail_stack #(
  parameter int VAR_BITS = 8,
  parameter int DEPTH = 256,
  localparam int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [VAR_BITS-1:0] var_in,
  input  logic                val_in,
  input  logic                type_in,
  input  logic                pop,
  input  logic                backtrack,
  output logic [VAR_BITS-1:0] var_out,
  output logic                val_out,
  output logic                type_out,
  output logic                empty,
  output logic                full,
  output logic [CNT_BITS-1:0] count,
  output logic [CNT_BITS-1:0] level,
  output logic                bt_busy,
  output logic                unassign_valid,
  output logic [VAR_BITS-1:0] unassign_var,
  output logic                bt_done,
  output logic                bt_none,
  output logic [VAR_BITS-1:0] flip_var,
  output logic                flip_val,
  output logic                overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UNWIND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [VAR_BITS-1:0] var_mem  [DEPTH];
  logic                val_mem  [DEPTH];
  logic                type_mem [DEPTH];

  logic [CNT_BITS-1:0] sp, sp_nxt, lvl, lvl_nxt;
  logic [1:0]          state, state_nxt;
  logic                ovf, ovf_nxt;

  logic [AW-1:0]       top_idx;
  logic [VAR_BITS-1:0] top_var;
  logic                top_val, top_type;
  logic                is_empty, is_full, in_unwind, flip_active;

  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic [VAR_BITS-1:0] wr_var;
  logic                wr_val, wr_type;

  // When sp == DEPTH the low bits wrap to 0, so top_idx still lands on DEPTH-1.
  assign top_idx  = sp[AW-1:0] - AW'(1);
  assign top_var  = var_mem[top_idx];
  assign top_val  = val_mem[top_idx];
  assign top_type = type_mem[top_idx];
  assign is_empty = (sp == '0);
  assign is_full  = (sp == CNT_BITS'(DEPTH));
  assign in_unwind = (state == S_UNWIND);

  assign var_out  = is_empty ? '0 : top_var;
  assign val_out  = !is_empty && top_val;
  assign type_out = !is_empty && top_type;
  assign empty    = is_empty;
  assign full     = is_full;
  assign count    = sp;
  assign level    = lvl;
  assign overflow = ovf;
  assign bt_busy  = in_unwind;

  assign unassign_valid = in_unwind && !is_empty && !top_type;
  assign unassign_var   = unassign_valid ? top_var : '0;
  assign flip_active    = in_unwind && !is_empty && top_type;
  assign bt_done        = in_unwind && (is_empty || top_type);
  assign bt_none        = in_unwind && is_empty;
  assign flip_var       = flip_active ? top_var : '0;
  assign flip_val       = flip_active && !top_val;

  always_comb begin
    sp_nxt    = sp;
    lvl_nxt   = lvl;
    ovf_nxt   = ovf;
    state_nxt = state;
    wr_en     = 1'b0;
    wr_idx    = sp[AW-1:0];
    wr_var    = var_in;
    wr_val    = val_in;
    wr_type   = type_in;
    case (state)
      S_UNWIND: begin
        if (is_empty) begin
          state_nxt = S_IDLE;
        end else if (!top_type) begin
          sp_nxt = sp - CNT_BITS'(1);
        end else begin
          // Flipped decision is stored as implied so the next backtrack passes it.
          wr_en     = 1'b1;
          wr_idx    = top_idx;
          wr_var    = top_var;
          wr_val    = !top_val;
          wr_type   = 1'b0;
          lvl_nxt   = lvl - CNT_BITS'(1);
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        if (backtrack) begin
          state_nxt = S_UNWIND;
        end else if (push && pop && !is_empty) begin
          wr_en   = 1'b1;
          wr_idx  = top_idx;
          lvl_nxt = lvl - CNT_BITS'(top_type) + CNT_BITS'(type_in);
        end else if (push) begin
          if (!is_full) begin
            wr_en   = 1'b1;
            sp_nxt  = sp + CNT_BITS'(1);
            lvl_nxt = lvl + CNT_BITS'(type_in);
          end else begin
            ovf_nxt = 1'b1;
          end
        end else if (pop && !is_empty) begin
          sp_nxt  = sp - CNT_BITS'(1);
          lvl_nxt = lvl - CNT_BITS'(top_type);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp    <= '0;
      lvl   <= '0;
      ovf   <= 1'b0;
      state <= S_IDLE;
    end else begin
      sp    <= sp_nxt;
      lvl   <= lvl_nxt;
      ovf   <= ovf_nxt;
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      var_mem[wr_idx]  <= wr_var;
      val_mem[wr_idx]  <= wr_val;
      type_mem[wr_idx] <= wr_type;
    end
  end

endmodule

// File: tb/tb_trail_stack.sv
// Bench for trail_stack: directed cases plus random commands against a queue-based
// model that expands each backtrack into its expected per-cycle event list.
module tb_trail_stack;
  localparam int VB = 8;
  localparam int DP = 4;
  localparam int CB = $clog2(DP) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0, backtrack = 1'b0;
  logic [VB-1:0] var_in = '0;
  logic          val_in = 1'b0, type_in = 1'b0;
  logic [VB-1:0] var_out, unassign_var, flip_var;
  logic          val_out, type_out, empty, full, bt_busy, unassign_valid;
  logic          bt_done, bt_none, flip_val, overflow;
  logic [CB-1:0] count, level;

  trail_stack #(.VAR_BITS(VB), .DEPTH(DP)) dut (
    .clock(clock), .reset(reset), .push(push), .var_in(var_in), .val_in(val_in),
    .type_in(type_in), .pop(pop), .backtrack(backtrack), .var_out(var_out),
    .val_out(val_out), .type_out(type_out), .empty(empty), .full(full),
    .count(count), .level(level), .bt_busy(bt_busy), .unassign_valid(unassign_valid),
    .unassign_var(unassign_var), .bt_done(bt_done), .bt_none(bt_none),
    .flip_var(flip_var), .flip_val(flip_val), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [VB-1:0] v; logic val; logic typ;} ent_t;
  // kind: 0 = unassign, 1 = flip, 2 = none
  typedef struct packed {logic [1:0] kind; logic [VB-1:0] v; logic val;} ev_t;

  ent_t stk[$];
  ev_t  evq[$];
  bit   m_ovf;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_level();
    int n = 0;
    foreach (stk[i]) if (stk[i].typ) n++;
    return n;
  endfunction

  task automatic check_outputs();
    int            n = stk.size();
    ent_t          top = '0;
    logic          e_uv = 1'b0, e_done = 1'b0, e_none = 1'b0, e_fval = 1'b0;
    logic [VB-1:0] e_uvar = '0, e_fvar = '0;
    if (n > 0) top = stk[n-1];
    if (evq.size() > 0) begin
      case (evq[0].kind)
        2'd0: begin e_uv = 1'b1; e_uvar = evq[0].v; end
        2'd1: begin e_done = 1'b1; e_fvar = evq[0].v; e_fval = evq[0].val; end
        default: begin e_done = 1'b1; e_none = 1'b1; end
      endcase
    end
    chk("count", 32'(count), 32'(n));
    chk("level", 32'(level), 32'(m_level()));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DP));
    chk("top_var", 32'(var_out), 32'(top.v));
    chk("top_val", 32'(val_out), 32'(top.val));
    chk("top_type", 32'(type_out), 32'(top.typ));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("bt_busy", 32'(bt_busy), 32'(evq.size() > 0));
    chk("unassign_valid", 32'(unassign_valid), 32'(e_uv));
    chk("unassign_var", 32'(unassign_var), 32'(e_uvar));
    chk("bt_done", 32'(bt_done), 32'(e_done));
    chk("bt_none", 32'(bt_none), 32'(e_none));
    chk("flip_var", 32'(flip_var), 32'(e_fvar));
    chk("flip_val", 32'(flip_val), 32'(e_fval));
  endtask

  task automatic model_update(input bit p, input bit po, input bit bt, input ent_t e);
    ent_t t;
    bit   found = 1'b0;
    if (evq.size() > 0) begin
      case (evq[0].kind)
        2'd0: void'(stk.pop_back());
        2'd1: begin t = stk.pop_back(); t.val = ~t.val; t.typ = 1'b0; stk.push_back(t); end
        default: ;
      endcase
      void'(evq.pop_front());
    end else if (bt) begin
      for (int i = stk.size() - 1; i >= 0 && !found; i--) begin
        if (stk[i].typ) begin
          evq.push_back({2'd1, stk[i].v, ~stk[i].val});
          found = 1'b1;
        end else begin
          evq.push_back({2'd0, stk[i].v, 1'b0});
        end
      end
      if (!found) evq.push_back({2'd2, {VB{1'b0}}, 1'b0});
    end else if (p && po && stk.size() > 0) begin
      void'(stk.pop_back());
      stk.push_back(e);
    end else if (p) begin
      if (stk.size() < DP) stk.push_back(e);
      else m_ovf = 1'b1;
    end else if (po && stk.size() > 0) begin
      void'(stk.pop_back());
    end
  endtask

  task automatic cycle(input bit p, input bit po, input bit bt,
                       input logic [VB-1:0] v, input bit va, input bit t);
    @(negedge clock);
    push = p; pop = po; backtrack = bt; var_in = v; val_in = va; type_in = t;
    check_outputs();
    @(posedge clock);
    model_update(p, po, bt, {v, va, t});
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int g = 0;
    while (evq.size() > 0 && g < DP + 4) begin idle(); g++; end
    chk("drain_timeout", 32'(evq.size()), 32'd0);
    idle();
  endtask

  initial begin
    #12;
    m_ovf = 1'b0;
    check_outputs();
    @(negedge clock); reset = 1'b1;

    // basic push / pop
    cycle(1, 0, 0, 8'd3, 1, 1);
    cycle(1, 0, 0, 8'd5, 0, 0);
    cycle(1, 0, 0, 8'd7, 1, 0);
    chk("tp1_count", 32'(count), 32'd3);
    chk("tp1_level", 32'(level), 32'd1);
    chk("tp1_top", 32'({var_out, val_out, type_out}), 32'({8'd7, 1'b1, 1'b0}));
    cycle(0, 1, 0, 8'd0, 0, 0);
    chk("tp1_pop_top", 32'({var_out, val_out, type_out}), 32'({8'd5, 1'b0, 1'b0}));

    // backtrack to decision 3, then to UNSAT
    cycle(1, 0, 0, 8'd7, 1, 0);
    cycle(0, 0, 1, 8'd0, 0, 0);
    drain();
    chk("tp2_top", 32'({var_out, val_out, type_out}), 32'({8'd3, 1'b0, 1'b0}));
    chk("tp2_level", 32'(level), 32'd0);
    cycle(0, 0, 1, 8'd0, 0, 0);
    drain();
    chk("tp3_empty", 32'(empty), 32'd1);

    // overflow at DEPTH, then pops including one on empty
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'(10 + i), i[0], i[1]);
    chk("tp4_full", 32'(full), 32'd1);
    chk("tp4_overflow", 32'(overflow), 32'd1);
    chk("tp4_top_var", 32'(var_out), 32'd13);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'd0, 0, 0);
    chk("tp4_count", 32'(count), 32'd0);

    // replace-in-place and push+backtrack
    cycle(1, 0, 0, 8'd5, 0, 0);
    cycle(1, 1, 0, 8'd9, 1, 1);
    chk("tp5_top", 32'({var_out, val_out, type_out}), 32'({8'd9, 1'b1, 1'b1}));
    chk("tp5_level", 32'(level), 32'd1);
    cycle(1, 0, 1, 8'd6, 0, 0);
    drain();

    // reset during the second unwind cycle
    cycle(1, 0, 0, 8'd1, 1, 1);
    cycle(1, 0, 0, 8'd2, 0, 0);
    cycle(1, 0, 0, 8'd4, 0, 0);
    cycle(0, 0, 1, 8'd0, 0, 0);
    idle();
    @(negedge clock);
    reset = 1'b0;
    #1;
    stk.delete(); evq.delete(); m_ovf = 1'b0;
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("rst_no_done", 32'(bt_done), 32'd0);
    end
    @(negedge clock); reset = 1'b1;

    // random commands
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 8, VB'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 35);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
